// File: rtl/ps2_kbd_rx.sv
// Host-side PS/2 keyboard receiver. It synchronises and de-glitches the PS/2
// clock, deserialises 11-bit device-to-host frames and decodes the
// scancode-set-2 prefixes E0 (extended), F0 (break) and E1 (pause).
//
// Event handshake: key_strobe is a one-cycle valid with no ready. The consumer
// must take key_code/key_pressed/key_extended in the cycle key_strobe is high.
// Those fields then hold their values until the next strobe.
module ps2_kbd_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 60000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          filt_done, fall;
  logic [TW-1:0] tcnt;
  logic          timeout;

  state_t        state, state_next;
  logic [2:0]    bit_cnt, bit_next;
  logic [7:0]    shift, shift_next;
  logic          par, par_next;
  logic          byte_ok, err;
  logic          rx_valid;

  logic          ext, brk;
  logic [2:0]    skip;
  logic          is_ctrl;

  // Two-flop synchronisers on both pins. They reset to the idle-high line level.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_kbd_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_kbd_data;
      dat_s2 <= dat_s1;
    end
  end

  // filt_done is true on the FILTER-th consecutive sample that differs from
  // the filtered level. A fall is that event while the filtered level is high.
  assign filt_done = (clk_s2 != filt_clk) && (filt_cnt == FW'(FILTER - 1));
  assign fall      = filt_done && filt_clk;

  // Clock filter: the level is accepted only after FILTER identical new samples.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == filt_clk) begin
      filt_cnt <= '0;
    end else if (filt_done) begin
      filt_clk <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  // Inter-edge timeout counter. It restarts on every fall and saturates.
  always_ff @(posedge clk_sys) begin
    if (reset || fall) begin
      tcnt <= '0;
    end else if (tcnt != TW'(TIMEOUT)) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT));

  // Frame FSM state register plus the pulses that hand results to the decoder.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      par       <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_next;
      bit_cnt   <= bit_next;
      shift     <= shift_next;
      par       <= par_next;
      rx_valid  <= byte_ok;
      frame_err <= err;
    end
  end

  // Frame FSM next-state logic. Every transition happens on a fall; the
  // timeout only applies when no fall occurs in the same cycle.
  always_comb begin
    state_next = state;
    bit_next   = bit_cnt;
    shift_next = shift;
    par_next   = par;
    byte_ok    = 1'b0;
    err        = 1'b0;
    if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s2) begin
            state_next = DATA;
            bit_next   = '0;
          end else begin
            err = 1'b1;
          end
        end
        DATA: begin
          shift_next = {dat_s2, shift[7:1]};
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_next = PARITY;
        end
        PARITY: begin
          par_next   = dat_s2;
          state_next = STOP;
        end
        STOP: begin
          state_next = IDLE;
          if (dat_s2 && (^{shift, par})) byte_ok = 1'b1;
          else                           err     = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
      err        = 1'b1;
    end
  end

  // Acknowledge and other control bytes are ignored unless a prefix is pending.
  assign is_ctrl = shift inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  // Prefix decoder. The shift register still holds the byte in the cycle
  // after the stop bit, because it only shifts again in DATA.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ext          <= 1'b0;
      brk          <= 1'b0;
      skip         <= '0;
      key_strobe   <= 1'b0;
      key_pressed  <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= '0;
    end else begin
      key_strobe <= 1'b0;
      if (frame_err) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (rx_valid) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (shift == 8'hE1) begin
          skip <= 3'd7;
        end else if (shift == 8'hE0) begin
          ext <= 1'b1;
        end else if (shift == 8'hF0) begin
          brk <= 1'b1;
        end else if (!(is_ctrl && !ext && !brk)) begin
          key_strobe   <= 1'b1;
          key_code     <= shift;
          key_pressed  <= ~brk;
          key_extended <= ext;
          ext          <= 1'b0;
          brk          <= 1'b0;
        end
      end
    end
  end

endmodule
